axi_rd_slave_model: RTL and testbench

Synthesizable AXI read slave that sits directly downstream of the reorder buffer's `axi_ar_out`/`axi_r_in` ports, standing in for the memory fabric. It accepts forwarded AR requests into a small request table and returns address-derived R bursts on the internal UID. Compiled with reordering, it serves requests newest-first, giving the ROB deterministic out-of-order returns to restore.

---
 rtl/axi_rd_slave_model.sv | 192 +++++++++++++++++++
 tb/tb_axi_rd_slave_model.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slave_model.sv
// AXI read slave standing in for the memory fabric behind the ROB.
// Define AXI_SLV_REORDER_EN to serve queued requests newest-first.
module axi_rd_slave_model #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH      = 4,
  parameter int MAX_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [LEN_WIDTH-1:0]  ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [RESP_WIDTH-1:0] r_resp,
  output logic                  r_last
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LEN_WIDTH:0] LMAX = (LEN_WIDTH + 1)'(MAX_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_count;

  logic [ID_WIDTH-1:0]  r_t_id   [DEPTH];
  logic [31:0]          r_t_addr [DEPTH];
  logic [LEN_WIDTH-1:0] r_t_len  [DEPTH];
  logic [2:0]           r_t_size [DEPTH];
  logic                 r_t_fix  [DEPTH];
  logic                 r_t_err  [DEPTH];

  logic [LEN_WIDTH-1:0]  r_a_len;
  logic [2:0]            r_a_size;
  logic                  r_a_fix;
  logic                  r_a_err;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [31:0]           r_baddr;
  logic                  r_rv;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [RESP_WIDTH-1:0] r_rresp;
  logic                  r_rlast;

  logic          w_acc;
  logic          w_fire;
  logic          w_pop;
  logic          w_adv;
  logic          w_err;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_widx;
  logic [31:0]   w_nb;

  function automatic logic [63:0] f_data(input logic e, input logic [31:0] a);
    return e ? 64'd0 : {a, ~a};
  endfunction

  assign ar_ready = rst && (r_count != CW'(DEPTH));
  assign w_acc    = ar_valid && ar_ready;
  assign w_fire   = r_rv && r_ready;
  assign w_err    = ar_burst[1] ||
                    (({1'b0, ar_len} + (LEN_WIDTH + 1)'(1)) > LMAX);
  assign w_nb     = r_a_fix ? r_baddr : r_baddr + (32'd1 << r_a_size);

  assign r_valid = r_rv;
  assign r_id    = r_rid;
  assign r_data  = r_rdata;
  assign r_resp  = r_rresp;
  assign r_last  = r_rlast;

`ifdef AXI_SLV_REORDER_EN
  // Stack: a same-cycle pop frees the top slot for the incoming entry.
  assign w_sel  = PW'(r_count - CW'(1));
  assign w_widx = w_pop ? w_sel : PW'(r_count);
`else
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;

  assign w_sel  = r_rptr;
  assign w_widx = r_wptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_acc)
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_fire && r_rlast) begin
          if (r_count != '0) w_pop = 1'b1;
          else               w_state_nxt = IDLE;
        end else if (w_fire) begin
          w_adv = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_acc && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_acc && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_t_id[w_widx]   <= ar_id;
      r_t_addr[w_widx] <= ar_addr[31:0];
      r_t_len[w_widx]  <= ar_len;
      r_t_size[w_widx] <= ar_size;
      r_t_fix[w_widx]  <= (ar_burst == 2'b00);
      r_t_err[w_widx]  <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_len  <= '0;
      r_a_size <= '0;
      r_a_fix  <= 1'b0;
      r_a_err  <= 1'b0;
      r_beat   <= '0;
      r_baddr  <= '0;
      r_rv     <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else if (w_pop) begin
      r_a_len  <= r_t_len[w_sel];
      r_a_size <= r_t_size[w_sel];
      r_a_fix  <= r_t_fix[w_sel];
      r_a_err  <= r_t_err[w_sel];
      r_beat   <= '0;
      r_baddr  <= r_t_addr[w_sel];
      r_rv     <= 1'b1;
      r_rid    <= r_t_id[w_sel];
      r_rdata  <= f_data(r_t_err[w_sel], r_t_addr[w_sel]);
      r_rresp  <= r_t_err[w_sel] ? RESP_WIDTH'(2) : '0;
      r_rlast  <= (r_t_len[w_sel] == '0);
    end else if (w_adv) begin
      r_beat   <= r_beat + LEN_WIDTH'(1);
      r_baddr  <= w_nb;
      r_rdata  <= f_data(r_a_err, w_nb);
      r_rlast  <= ((r_beat + LEN_WIDTH'(1)) == r_a_len);
    end else if (w_fire && r_rlast) begin
      r_rv     <= 1'b0;
      r_rlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rd_slave_model.sv
// Directed bench for axi_rd_slave_model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_rd_slave_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid;
  logic        ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_rd_slave_model dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b);
    logic hs;
    int   n;
    ar_id = id; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b;
    ar_valid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      hs = ar_ready;
      step();
      n++;
    end
    ar_valid = 1'b0;
    if (!hs) begin
      n_tests++; n_fail++;
      $display("FAIL send_ar id=%0d: ar_ready got 0, required 1", id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; r_ready = 1'b1; ar_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    step(); step();
    n_tests++;
    if ({ar_ready, r_valid, r_last} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000",
               {ar_ready, r_valid, r_last});
    end
    n_tests++;
    if ({r_id, r_data, r_resp} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_data: got id=%h data=%h resp=%h required 0",
               r_id, r_data, r_resp);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b required 1", ar_ready);
    end
  endtask

  task automatic test_single();
    r_ready = 1'b1;
    send_ar(4'd0, 32'h0000_1000, 8'd0, 3'd3, 2'b01);
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: r_valid got %b required 0", r_valid);
    end
    step();
    n_tests++;
    if ({r_valid, r_id, r_data, r_resp, r_last} !==
        {1'b1, 4'd0, 64'h0000_1000_FFFF_EFFF, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL single_beat: got v=%b id=%h d=%h r=%b l=%b required v=1 id=0 d=00001000ffffefff r=00 l=1",
               r_valid, r_id, r_data, r_resp, r_last);
    end
    step();
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: r_valid got %b required 0", r_valid);
    end
  endtask

  task automatic test_incr();
    logic [31:0] lo;
    r_ready = 1'b1;
    send_ar(4'd2, 32'h0000_4000, 8'd3, 3'd3, 2'b01);
    step();
    for (int i = 0; i < 4; i++) begin
      lo = 32'h4000 + 32'(i * 8);
      n_tests++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !==
          {1'b1, 4'd2, lo, ~lo, 2'b00, (i == 3)}) begin
        n_fail++;
        $display("FAIL incr_beat%0d: got v=%b id=%h d=%h l=%b required d=%h l=%b",
                 i, r_valid, r_id, r_data, r_last, {lo, ~lo}, (i == 3));
      end
      step();
    end
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_done: r_valid got %b required 0", r_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lo;
    r_ready = 1'b1;
    send_ar(4'd5, 32'h0000_2000, 8'd3, 3'd2, 2'b01);
    step();
    n_tests++;
    if (r_data !== 64'h0000_2000_FFFF_DFFF) begin
      n_fail++;
      $display("FAIL bp_beat0: got %h required 00002000ffffdfff", r_data);
    end
    step();
    r_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if ({r_valid, r_id, r_data, r_last} !==
          {1'b1, 4'd5, 64'h0000_2004_FFFF_DFFB, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b id=%h d=%h l=%b required v=1 id=5 d=00002004ffffdffb l=0",
                 c, r_valid, r_id, r_data, r_last);
      end
    end
    r_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      lo = 32'h2000 + 32'(i * 4);
      n_tests++;
      if ({r_valid, r_data, r_last} !== {1'b1, lo, ~lo, (i == 3)}) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got v=%b d=%h l=%b required d=%h l=%b",
                 i, r_valid, r_data, r_last, {lo, ~lo}, (i == 3));
      end
      step();
    end
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: r_valid got %b required 0", r_valid);
    end
  endtask

  task automatic test_fill_order();
    logic [3:0]  exp_id [5];
    logic [31:0] lo;
`ifdef AXI_SLV_REORDER_EN
    exp_id = '{4'd7, 4'd4, 4'd3, 4'd2, 4'd1};
`else
    exp_id = '{4'd7, 4'd1, 4'd2, 4'd3, 4'd4};
`endif
    r_ready = 1'b0;
    send_ar(4'd7, 32'h0000_0700, 8'd0, 3'd3, 2'b01);
    step();
    for (int k = 1; k <= 4; k++)
      send_ar(4'(k), 32'(k * 256), 8'd0, 3'd3, 2'b01);
    ar_id = 4'd6; ar_addr = 32'h600; ar_len = 8'd0; ar_valid = 1'b1;
    #1;
    n_tests++;
    if (ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b required 0", ar_ready);
    end
    step();
    n_tests++;
    if ({ar_ready, r_id} !== {1'b0, 4'd7}) begin
      n_fail++;
      $display("FAIL full_hold: got ready=%b id=%h required ready=0 id=7",
               ar_ready, r_id);
    end
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lo = 32'(exp_id[k]) * 32'd256;
      n_tests++;
      if ({r_valid, r_id, r_data, r_last} !==
          {1'b1, exp_id[k], lo, ~lo, 1'b1}) begin
        n_fail++;
        $display("FAIL order%0d: got v=%b id=%h d=%h l=%b required v=1 id=%h d=%h l=1",
                 k, r_valid, r_id, r_data, r_last, exp_id[k], {lo, ~lo});
      end
      step();
    end
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL order_done: r_valid got %b required 0", r_valid);
    end
  endtask

  task automatic test_errors();
    r_ready = 1'b1;
    send_ar(4'd3, 32'h0000_0500, 8'd8, 3'd3, 2'b01);
    step();
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !==
          {1'b1, 4'd3, 64'd0, 2'b10, (i == 8)}) begin
        n_fail++;
        $display("FAIL len_err%0d: got v=%b id=%h d=%h r=%b l=%b required v=1 id=3 d=0 r=10 l=%b",
                 i, r_valid, r_id, r_data, r_resp, r_last, (i == 8));
      end
      step();
    end
    send_ar(4'd4, 32'h0000_0800, 8'd1, 3'd3, 2'b11);
    step();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !==
          {1'b1, 4'd4, 64'd0, 2'b10, (i == 1)}) begin
        n_fail++;
        $display("FAIL burst_err%0d: got v=%b id=%h d=%h r=%b l=%b required v=1 id=4 d=0 r=10 l=%b",
                 i, r_valid, r_id, r_data, r_resp, r_last, (i == 1));
      end
      step();
    end
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_done: r_valid got %b required 0", r_valid);
    end
  endtask

  task automatic test_wrap_fixed();
    r_ready = 1'b1;
    send_ar(4'd1, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
    step();
    n_tests++;
    if ({r_data, r_resp} !== {64'hFFFF_FFF8_0000_0007, 2'b00}) begin
      n_fail++;
      $display("FAIL wrap_beat0: got %h/%b required ffffffF800000007/00",
               r_data, r_resp);
    end
    step();
    n_tests++;
    if ({r_data, r_last} !== {64'h0000_0000_FFFF_FFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_beat1: got %h l=%b required 00000000ffffffff l=1",
               r_data, r_last);
    end
    step();
    send_ar(4'd8, 32'h0000_3000, 8'd1, 3'd3, 2'b00);
    step();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({r_valid, r_data, r_last} !==
          {1'b1, 64'h0000_3000_FFFF_CFFF, (i == 1)}) begin
        n_fail++;
        $display("FAIL fixed_beat%0d: got v=%b d=%h l=%b required d=00003000ffffcfff l=%b",
                 i, r_valid, r_data, r_last, (i == 1));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    r_ready = 1'b1;
    send_ar(4'd9, 32'h0000_6000, 8'd3, 3'd3, 2'b01);
    send_ar(4'd10, 32'h0000_7000, 8'd0, 3'd3, 2'b01);
    step();
    n_tests++;
    if ({r_valid, r_id, r_data[31:0]} !== {1'b1, 4'd9, ~32'h6008}) begin
      n_fail++;
      $display("FAIL mid_beat1: got v=%b id=%h d=%h required v=1 id=9 low=ffff9ff7",
               r_valid, r_id, r_data);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: r_valid got %b required 0", r_valid);
    end
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (r_valid === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_after: beats got %0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_backpressure();
    test_fill_order();
    test_errors();
    test_wrap_fixed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
